// File: rtl/vector_req_arbiter.sv
// Round-robin arbiter sharing the consumer port of the vector ring buffer
// between NB_REQ requesters, with bounded retry on an empty buffer.
module vector_req_arbiter #(
    parameter int unsigned NB_REQ      = 4,
    parameter int unsigned VEC_W       = 8,
    parameter int unsigned RETRY_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NB_REQ-1:0]         cons_req,
    output logic [VEC_W-1:0]          cons_vector,
    output logic [NB_REQ-1:0]         cons_valid,
    output logic [NB_REQ-1:0]         cons_miss,
    output logic [$clog2(NB_REQ)-1:0] grant_id,
    output logic                      busy,
    output logic                      buf_req,
    input  logic [VEC_W-1:0]          buf_vector,
    input  logic                      buf_valid
);

    localparam int unsigned ID_W  = $clog2(NB_REQ);
    localparam int unsigned CNT_W = $clog2(RETRY_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_n;
    logic [CNT_W-1:0]   retry_cnt, retry_cnt_n;
    logic               buf_req_n;
    logic [NB_REQ-1:0]  cons_valid_n, cons_miss_n;
    logic [VEC_W-1:0]   cons_vector_n;
    logic [ID_W-1:0]    grant_id_n;
    logic               busy_n;

    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    int unsigned        cand;
    logic [ID_W-1:0]    cand_id;
    logic [ID_W-1:0]    ptr_after_grant;
    logic [NB_REQ-1:0]  grant_onehot;
    logic               retry_left;

    // First pending request at or after rr_ptr, wrapping modulo NB_REQ
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_id    = '0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= NB_REQ) begin
                cand = cand - NB_REQ;
            end
            cand_id = ID_W'(cand);
            if (!pick_found && cons_req[cand_id]) begin
                pick_found = 1'b1;
                pick_idx   = cand_id;
            end
        end
    end

    // Helpers derived from the current grant
    always_comb begin
        ptr_after_grant = (grant_id == ID_W'(NB_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        grant_onehot    = NB_REQ'(1) << grant_id;
        retry_left      = (32'(retry_cnt) + 1) < RETRY_LIMIT;
    end

    // Next-state and registered-output computation
    always_comb begin
        state_n       = state;
        rr_ptr_n      = rr_ptr;
        retry_cnt_n   = retry_cnt;
        buf_req_n     = 1'b0;
        cons_valid_n  = '0;
        cons_miss_n   = '0;
        cons_vector_n = cons_vector;
        grant_id_n    = grant_id;

        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_id_n  = pick_idx;
                    retry_cnt_n = '0;
                    buf_req_n   = 1'b1;
                    state_n     = ST_REQ;
                end
            end
            ST_REQ: begin
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (buf_valid) begin
                    cons_vector_n = buf_vector;
                    cons_valid_n  = grant_onehot;
                    rr_ptr_n      = ptr_after_grant;
                    state_n       = ST_IDLE;
                end else if (retry_left) begin
                    retry_cnt_n = retry_cnt + CNT_W'(1);
                    buf_req_n   = 1'b1;
                    state_n     = ST_REQ;
                end else begin
                    cons_miss_n = grant_onehot;
                    rr_ptr_n    = ptr_after_grant;
                    state_n     = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            retry_cnt   <= '0;
            buf_req     <= 1'b0;
            cons_valid  <= '0;
            cons_miss   <= '0;
            cons_vector <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_ptr_n;
            retry_cnt   <= retry_cnt_n;
            buf_req     <= buf_req_n;
            cons_valid  <= cons_valid_n;
            cons_miss   <= cons_miss_n;
            cons_vector <= cons_vector_n;
            grant_id    <= grant_id_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: doc/vector_req_arbiter.md
Name: vector_req_arbiter

Overview:
- Shares the consumer side of the vector ring buffer between NB_REQ requesters using round-robin arbitration.
- Issues single-cycle req pulses to the buffer and captures the registered vector/valid response on the following cycle.
- Routes each captured vector to the granted requester.
- Retries a bounded number of times while the buffer is empty, then reports a miss so requesters never hang.

Parameters:
- NB_REQ, 4, number of requesters; must be ≥2.
- VEC_W, 8, vector width; matches the buffer's vector port.
- RETRY_LIMIT, 3, maximum buffer requests per grant before a miss is reported; must be ≥1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- cons_req  input  NB_REQ  per-requester level request; held until that requester's cons_valid or cons_miss pulse.
- cons_vector  output  VEC_W  delivered vector, broadcast to all requesters; qualified by cons_valid.
- cons_valid  output  NB_REQ  one-hot, 1-cycle pulse; delivery to requester i.
- cons_miss  output  NB_REQ  one-hot, 1-cycle pulse; requester i gave up after RETRY_LIMIT empty responses.
- grant_id  output  $clog2(NB_REQ)  index of the requester currently granted; valid while busy=1.
- busy  output  1  high in states REQ and WAIT.
- buf_req  output  1  request to buffer; registered.
- buf_vector  input  VEC_W  buffer data; valid in the cycle after buf_req=1.
- buf_valid  input  1  buffer response valid; 0 means the buffer was empty.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; rr_ptr=0; retry_cnt=0.
  - buf_req=0, cons_valid=0, cons_miss=0, cons_vector=0, grant_id=0, busy=0.
  - Any in-flight buffer response is discarded: buf_valid is ignored outside WAIT.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If cons_req is nonzero, select the first set bit searching rr_ptr, rr_ptr+1, …, wrapping modulo NB_REQ.
  - Latch it into grant_id, set retry_cnt=0, set buf_req=1, go to REQ.
  - Otherwise stay in IDLE.
- REQ: lasts exactly one cycle with buf_req=1; at the edge set buf_req=0 and go to WAIT.
- WAIT: sample buf_valid at the edge.
  - buf_valid=1:
    - cons_vector<=buf_vector; cons_valid[grant_id]<=1 for one cycle.
    - rr_ptr<=grant_id+1, wrapping NB_REQ-1 to 0.
    - Go to IDLE.
  - buf_valid=0 and retry_cnt+1<RETRY_LIMIT: retry_cnt++; buf_req<=1; go to REQ.
  - buf_valid=0 and retry_cnt+1==RETRY_LIMIT:
    - cons_miss[grant_id]<=1 for one cycle; cons_vector unchanged.
    - rr_ptr<=grant_id+1; go to IDLE.
- Latency, measured from the cycle cons_req is seen in IDLE (cycle 0):
  - buf_req is high in cycle 1.
  - buf_valid/buf_vector are sampled at the end of cycle 2.
  - cons_valid is high in cycle 3.
- Throughput: at most one vector per 3 cycles. The IDLE cycle coincident with a cons_valid/cons_miss pulse may start the next grant.
- A requester's cons_req is not re-evaluated during REQ/WAIT.
  - Dropping cons_req mid-transaction does not abort it; the vector is still delivered with cons_valid, so no vector is lost.
  - A requester that keeps cons_req high after cons_valid is re-arbitrated normally; fairness comes from the rr_ptr advance.
- cons_vector holds its last delivered value between deliveries; only cons_valid qualifies it.
- rr_ptr advances only on completion (valid or miss), never on a retry.
- Starvation bound: a held request is granted within NB_REQ-1 other grants.
- Simultaneous events:
  - A new cons_req arriving during REQ/WAIT waits for IDLE.
  - Reset asserted in any state wins over every transition.
- buf_valid=1 seen in IDLE or REQ (not expected from the buffer) is ignored.

Test Plan:
- Reset, then buffer holds vectors 0xA5,0x3C; cons_req=0001 held → buf_req high in cycle 1; cons_valid=0001 with cons_vector=0xA5 in cycle 3; buffer's next vector is 0x3C.
- cons_req=1111 held continuously, buffer always non-empty → grants in order 0,1,2,3,0; cons_valid pulses exactly every 3 cycles; each pulse is one-hot.
- Buffer empty, cons_req=0100, RETRY_LIMIT=3 → three buf_req pulses 2 cycles apart; cons_miss=0100 for one cycle; cons_valid stays 0; rr_ptr becomes 3.
- Buffer empty for the first request, then the producer fills a vector 0x7E → second WAIT sees buf_valid=1; cons_valid[g] with 0x7E; no cons_miss.
- rr_ptr=3, cons_req=1001 → requester 3 granted first, then requester 0; with cons_req=0010 only, requester 1 is granted despite rr_ptr=3 (wrap search).
- Assert rst_n=0 during WAIT while the buffer returns buf_valid=1 → no cons_valid pulse; all outputs 0 next cycle; state IDLE. After rst_n=1, a new request completes normally.
